// File: rtl/sd_cmd_framer_pkg.sv
// Shared definitions for the SD command-line framer: frame geometry,
// CRC7 polynomial, FSM state encoding and the frame bit selector.
package sd_cmd_framer_pkg;

  localparam logic [5:0] FRAME_LEN = 6'd48;  // start, dir, index, arg, crc7, end
  localparam logic [5:0] CRC_POS   = 6'd40;  // first CRC bit; CRC covers bits 0..39
  localparam logic [6:0] CRC_POLY  = 7'h09;  // x^7 + x^3 + 1, x^7 implicit

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEND,
    ST_GAP
  } state_e;

  // Bit n of the frame (n=0 is the first bit on the wire).
  function automatic logic frame_bit(input logic [39:0] hdr,
                                     input logic [6:0]  crc,
                                     input logic [5:0]  n);
    if (n < CRC_POS)
      return hdr[6'd39 - n];
    else if (n < FRAME_LEN - 6'd1)
      return crc[3'(6'd46 - n)];
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/sd_cmd_framer_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, zero seed) fed one bit per valid cycle.
module crc7_serial
  import sd_cmd_framer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic       valid_i,
  input  logic       data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  // One LFSR step for the incoming bit.
  always_comb begin
    fb    = data_i ^ crc_q[6];
    crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
  end

  // Clear has priority so a new frame always starts from a zero seed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     crc_q <= 7'h00;
    else if (clr_i)   crc_q <= 7'h00;
    else if (valid_i) crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_framer.sv
// SD command framer: serialises a 48-bit command frame, one bit per
// bit_en_i strobe, with CRC7 generated on the fly.
// Optional feature macro: SD_CMD_GAP_EN adds IDLE_BITS released-line
// strobes after the end bit before DONE.
//
//   state   | meaning
//   IDLE    | waiting for start_i, line released
//   ARM     | command latched, waiting for the first strobe
//   SEND    | driving frame bits 0..47, one per strobe
//   GAP     | line released, counting post-frame idle strobes
module sd_cmd_framer
  import sd_cmd_framer_pkg::*;
#(
  parameter int unsigned IDLE_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        bit_en_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe_o
);

`ifdef SD_CMD_GAP_EN
  localparam int unsigned GAP_LEN = IDLE_BITS;
  localparam int unsigned GW      = $clog2(GAP_LEN + 2);
  logic [GW-1:0] gap_cnt_q;
`else
  // Gap compiled out; the parameter stays for a uniform interface.
  localparam int unsigned GAP_LEN = 0 * IDLE_BITS;
`endif

  state_e      state_q;
  logic        busy_q, done_q, sd_cmd_q, oe_q;
  logic [5:0]  bit_cnt_q;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;

  logic [39:0] hdr;
  logic [6:0]  crc;
  logic [5:0]  nxt_bit;
  logic        cur_bit;
  logic        crc_clr;
  logic        crc_en;

  assign hdr     = {2'b01, idx_q, arg_q};
  assign nxt_bit = (state_q == ST_ARM) ? 6'd0 : bit_cnt_q + 6'd1;
  assign cur_bit = frame_bit(hdr, crc, nxt_bit);
  assign crc_clr = (state_q == ST_IDLE) && start_i && !done_q;
  // CRC follows the line for bits 0..39 and freezes before it is shifted out.
  assign crc_en  = bit_en_i && ((state_q == ST_ARM) ||
                                ((state_q == ST_SEND) && (nxt_bit < CRC_POS)));

  crc7_serial u_crc (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (crc_clr),
    .valid_i (crc_en),
    .data_i  (cur_bit),
    .crc_o   (crc)
  );

  // Framer FSM with registered line, enable and handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sd_cmd_q  <= 1'b1;
      oe_q      <= 1'b0;
      bit_cnt_q <= 6'd0;
      idx_q     <= 6'd0;
      arg_q     <= 32'd0;
`ifdef SD_CMD_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // A START coinciding with DONE belongs to the finished frame.
          if (start_i && !done_q) begin
            idx_q     <= cmd_idx_i;
            arg_q     <= cmd_arg_i;
            busy_q    <= 1'b1;
            bit_cnt_q <= 6'd0;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (bit_en_i) begin
            sd_cmd_q  <= cur_bit;
            oe_q      <= 1'b1;
            bit_cnt_q <= 6'd0;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bit_en_i) begin
            if (bit_cnt_q == FRAME_LEN - 6'd1) begin
              oe_q      <= 1'b0;
              sd_cmd_q  <= 1'b1;
              bit_cnt_q <= 6'd0;
              if (GAP_LEN == 0) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end
`ifdef SD_CMD_GAP_EN
              else begin
                gap_cnt_q <= GW'(GAP_LEN);
                state_q   <= ST_GAP;
              end
`endif
            end else begin
              bit_cnt_q <= nxt_bit;
              sd_cmd_q  <= cur_bit;
            end
          end
        end
        ST_GAP: begin
`ifdef SD_CMD_GAP_EN
          if (bit_en_i) begin
            if (gap_cnt_q == GW'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q - GW'(1);
            end
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sd_cmd_o    = sd_cmd_q;
  assign sd_cmd_oe_o = oe_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Self-checking bench for sd_cmd_framer: directed frames, randomised
// frames against a polynomial-division reference, mid-frame reset.
module tb_sd_cmd_framer;

`ifdef SD_CMD_GAP_EN
  localparam int EXP_GAP = 8;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        bit_en_i;
  logic        start_i;
  logic [5:0]  cmd_idx_i;
  logic [31:0] cmd_arg_i;
  logic        busy_o, done_o, sd_cmd_o, sd_cmd_oe_o;

  int checks = 0;
  int failures = 0;

  sd_cmd_framer #(.IDLE_BITS(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bit_en_i    (bit_en_i),
    .start_i     (start_i),
    .cmd_idx_i   (cmd_idx_i),
    .cmd_arg_i   (cmd_arg_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sd_cmd_o    (sd_cmd_o),
    .sd_cmd_oe_o (sd_cmd_oe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference frame: CRC7 as remainder of (message * x^7) mod (x^7+x^3+1).
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [46:0] r;
    logic [46:0] poly;
    h = {2'b01, idx, arg};
    r = {h, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) begin
        poly = 47'h89;
        r = r ^ (poly << (i - 7));
      end
    end
    return {h, r[6:0], 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe();
    bit_en_i = 1'b1;
    tick();
    bit_en_i = 1'b0;
  endtask

  // Send one frame with a strobe every `period` clocks; optionally poke
  // START and change the command inputs mid-frame.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int period,
                           input bit poke, input string tag, output logic [47:0] got);
    logic last;
    bit   hold_ok, oe_ok, gap_ok;
    int   lat;
    cmd_idx_i = idx;
    cmd_arg_i = arg;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    check({tag, ".busy_on"}, 48'(busy_o), 48'd1);
    check({tag, ".arm_oe"}, 48'(sd_cmd_oe_o), 48'd0);
    hold_ok = 1'b1;
    oe_ok   = 1'b1;
    gap_ok  = 1'b1;
    got     = '0;
    last    = 1'b1;
    for (int b = 0; b < 48; b++) begin
      for (int w = 1; w < period; w++) begin
        tick();
        if (b > 0 && (sd_cmd_o !== last || sd_cmd_oe_o !== 1'b1)) hold_ok = 1'b0;
      end
      if (poke && b == 10) begin
        start_i   = 1'b1;
        cmd_idx_i = ~idx;
        cmd_arg_i = ~arg;
      end
      strobe();
      start_i = 1'b0;
      got[47 - b] = sd_cmd_o;
      last = sd_cmd_o;
      if (sd_cmd_oe_o !== 1'b1 || busy_o !== 1'b1) oe_ok = 1'b0;
    end
    check({tag, ".frame"}, got, model_frame(idx, arg));
    check({tag, ".hold"}, 48'(hold_ok), 48'd1);
    check({tag, ".oe_busy"}, 48'(oe_ok), 48'd1);
    for (int w = 1; w < period; w++) tick();
    strobe();
    check({tag, ".rel_oe"}, 48'(sd_cmd_oe_o), 48'd0);
    check({tag, ".rel_cmd"}, 48'(sd_cmd_o), 48'd1);
    lat = 0;
    if (done_o !== 1'b1) begin
      lat = -1;
      for (int k = 1; k <= EXP_GAP + 4; k++) begin
        for (int w = 1; w < period; w++) tick();
        strobe();
        if (sd_cmd_oe_o !== 1'b0 || sd_cmd_o !== 1'b1) gap_ok = 1'b0;
        if (done_o === 1'b1) begin
          lat = k;
          break;
        end
      end
    end
    check({tag, ".done_lat"}, 48'(lat), 48'(EXP_GAP));
    check({tag, ".gap_line"}, 48'(gap_ok), 48'd1);
    check({tag, ".busy_off"}, 48'(busy_o), 48'd0);
    // START in the DONE cycle must be ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, ".done_pulse"}, 48'(done_o), 48'd0);
    check({tag, ".start_in_done"}, 48'(busy_o), 48'd0);
  endtask

  initial begin
    logic [47:0] g1, g2;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    rst_n_i   = 1'b0;
    bit_en_i  = 1'b0;
    start_i   = 1'b0;
    cmd_idx_i = '0;
    cmd_arg_i = '0;
    repeat (3) tick();
    check("rst.busy", 48'(busy_o), 48'd0);
    check("rst.done", 48'(done_o), 48'd0);
    check("rst.cmd", 48'(sd_cmd_o), 48'd1);
    check("rst.oe", 48'(sd_cmd_oe_o), 48'd0);
    rst_n_i = 1'b1;
    tick();

    repeat (5) strobe();
    check("idle_strobe.busy", 48'(busy_o), 48'd0);
    check("idle_strobe.line", 48'({sd_cmd_oe_o, sd_cmd_o}), 48'b01);

    run_frame(6'd0, 32'd0, 1, 1'b0, "cmd0", g1);
    check("cmd0.const", g1, 48'h400000000095);

    run_frame(6'd8, 32'h000001AA, 4, 1'b0, "cmd8", g1);
    check("cmd8.const", g1, 48'h48000001AA87);

    run_frame(6'd17, 32'd0, 2, 1'b1, "cmd17", g1);
    check("cmd17.const", g1, 48'h510000000055);
    repeat (6) strobe();
    check("cmd17.no_extra", 48'({busy_o, sd_cmd_oe_o}), 48'd0);

    // Reset in the middle of a frame, right after bit 20 is driven.
    ridx = 6'($urandom);
    rarg = $urandom;
    cmd_idx_i = ridx;
    cmd_arg_i = rarg;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (21) strobe();
    check("midrst.pre_oe", 48'(sd_cmd_oe_o), 48'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("midrst.oe", 48'(sd_cmd_oe_o), 48'd0);
    check("midrst.cmd", 48'(sd_cmd_o), 48'd1);
    check("midrst.busy", 48'(busy_o), 48'd0);
    tick();
    rst_n_i = 1'b1;
    repeat (4) strobe();
    check("midrst.quiet", 48'({busy_o, sd_cmd_oe_o}), 48'd0);
    run_frame(ridx, rarg, 1, 1'b0, "midrst.resend", g1);

    // Same command at two strobe rates must give the same bit sequence.
    ridx = 6'($urandom);
    rarg = $urandom;
    run_frame(ridx, rarg, 1, 1'b0, "rate1", g1);
    run_frame(ridx, rarg, 4, 1'b0, "rate4", g2);
    check("rate.same", g2, g1);

    for (int n = 0; n < 6; n++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      run_frame(ridx, rarg, int'($urandom_range(1, 3)), n[0], $sformatf("rnd%0d", n), g1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
